// File: rtl/rv_muldiv_ctrl_pkg.sv
// Shared types for the execute-stage ALU and its iterative multiply/divide sequencer.
// Holds the FSM state encodings, the RV32M funct3 codes and the signedness decode.
package rv_muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_IDLE = 2'd0,
        ALU_EXEC = 2'd1,
        ALU_WAIT = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_END  = 2'd2,
        MD_SPEC = 2'd3
    } muldiv_state_t;

    localparam int unsigned MD_CNT_W = 6;
    localparam int unsigned XLEN     = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic op1;
        logic op2;
        logic dr;
        logic div;
        logic rem;
    } sign_ctrl_t;

    // fs = funct3[1:0]; the same two bits mean different things for mul and div,
    // so each control is a plain function of fs and the datapath picks what it needs.
    function automatic sign_ctrl_t decode_sign(input logic [1:0] fs);
        sign_ctrl_t s;
        s.op1 = !(fs == 2'b11);
        s.op2 = !fs[1];
        s.dr  = !fs[0];
        s.div = (fs == 2'b00);
        s.rem = (fs == 2'b10);
        return s;
    endfunction

endpackage

// File: rtl/rv_muldiv_ctrl_special.sv
// Combinational detector for divisions that resolve without iterating:
// divide-by-zero and the signed INT_MIN / -1 overflow.
module rv_muldiv_special
    import rv_muldiv_ctrl_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_special,
    output logic [XLEN-1:0] o_bypass_data
);

    logic is_div;
    logic is_rem;
    logic is_signed;
    logic div_zero;
    logic overflow;

    assign is_div    = i_funct3[2];
    assign is_rem    = i_funct3[1];
    assign is_signed = !i_funct3[0];
    assign div_zero  = (i_op2 == '0);
    assign overflow  = is_signed && (i_op1 == INT_MIN) && (i_op2 == ALL_ONE);

    assign o_special = is_div && (div_zero || overflow);

    always_comb begin
        o_bypass_data = '0;
        if (is_div) begin
            // Zero divisor wins over overflow when both could apply.
            if (div_zero) begin
                o_bypass_data = is_rem ? i_op1 : ALL_ONE;
            end else if (overflow) begin
                o_bypass_data = is_rem ? '0 : INT_MIN;
            end
        end
    end

endmodule

// File: rtl/rv_muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath: accepts one
// M-extension op, counts iterations, and short-circuits special divisions.
module rv_muldiv_ctrl
    import rv_muldiv_ctrl_pkg::*;
#(
    parameter bit          EXTENSION_M = 1'b1,
    parameter int unsigned MUL_ITER    = 31,
    parameter int unsigned DIV_ITER    = 33
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_flush,
    input  logic                i_start,
    input  logic [2:0]          i_funct3,
    input  logic [XLEN-1:0]     i_op1,
    input  logic [XLEN-1:0]     i_op2,
    output logic                o_ready,
    output logic                o_on_wait,
    output logic                o_on_end,
    output logic                o_is_div,
    output logic [MD_CNT_W-1:0] o_op_cnt,
    output logic                o_op1_signed,
    output logic                o_op2_signed,
    output logic                o_dr_signed,
    output logic                o_div_signed,
    output logic                o_rem_signed,
    output logic                o_done,
    output logic                o_bypass,
    output logic [XLEN-1:0]     o_bypass_data
);

    if (EXTENSION_M) begin : g_md
        muldiv_state_t         state_q, state_d;
        logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
        logic [MD_CNT_W-1:0]   limit_m1;
        logic                  is_div_q;
        sign_ctrl_t            sign_q;
        logic [XLEN-1:0]       bypass_data_q;
        logic                  special;
        logic [XLEN-1:0]       special_data;
        logic                  accept;

        rv_muldiv_special u_special (
            .i_funct3      (i_funct3),
            .i_op1         (i_op1),
            .i_op2         (i_op2),
            .o_special     (special),
            .o_bypass_data (special_data)
        );

        assign accept   = (state_q == MD_IDLE) && i_start && !i_flush;
        assign limit_m1 = is_div_q ? MD_CNT_W'(DIV_ITER - 1) : MD_CNT_W'(MUL_ITER - 1);

        always_comb begin
            state_d = state_q;
            case (state_q)
                MD_IDLE: if (i_start) state_d = special ? MD_SPEC : MD_RUN;
                MD_RUN:  if (cnt_q == limit_m1) state_d = MD_END;
                MD_END:  state_d = MD_IDLE;
                MD_SPEC: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
            if (i_flush) state_d = MD_IDLE;

            // END always returns to IDLE, so only RUN needs to carry the count forward;
            // this keeps the counter at zero whenever the block is idle.
            cnt_d = '0;
            if (state_q == MD_RUN && state_d != MD_IDLE) cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                state_q       <= MD_IDLE;
                cnt_q         <= '0;
                is_div_q      <= 1'b0;
                sign_q        <= '0;
                bypass_data_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (accept) begin
                    is_div_q      <= i_funct3[2];
                    sign_q        <= decode_sign(i_funct3[1:0]);
                    bypass_data_q <= special_data;
                end
            end
        end

        assign o_ready       = (state_q == MD_IDLE);
        assign o_on_wait     = (state_q == MD_RUN);
        assign o_on_end      = (state_q == MD_END);
        assign o_done        = (state_q == MD_END) || (state_q == MD_SPEC);
        assign o_bypass      = (state_q == MD_SPEC);
        assign o_is_div      = is_div_q;
        assign o_op_cnt      = cnt_q;
        assign o_op1_signed  = sign_q.op1;
        assign o_op2_signed  = sign_q.op2;
        assign o_dr_signed   = sign_q.dr;
        assign o_div_signed  = sign_q.div;
        assign o_rem_signed  = sign_q.rem;
        assign o_bypass_data = bypass_data_q;
    end else begin : g_no_md
        logic unused_inputs;
        assign unused_inputs = ^{i_clk, i_reset_n, i_flush, i_start, i_funct3, i_op1, i_op2};

        assign o_ready       = 1'b1;
        assign o_on_wait     = 1'b0;
        assign o_on_end      = 1'b0;
        assign o_done        = 1'b0;
        assign o_bypass      = 1'b0;
        assign o_is_div      = 1'b0;
        assign o_op_cnt      = '0;
        assign o_op1_signed  = 1'b0;
        assign o_op2_signed  = 1'b0;
        assign o_dr_signed   = 1'b0;
        assign o_div_signed  = 1'b0;
        assign o_rem_signed  = 1'b0;
        assign o_bypass_data = '0;
    end

endmodule

// File: tb/tb_rv_muldiv_ctrl.sv
// Directed bench for rv_muldiv_ctrl: latency, signedness decode, special divisions,
// flush/reset aborts and ignored starts while busy.
module tb_rv_muldiv_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic        o_ready, o_on_wait, o_on_end, o_is_div;
    logic [5:0]  o_op_cnt;
    logic        o_op1_signed, o_op2_signed, o_dr_signed, o_div_signed, o_rem_signed;
    logic        o_done, o_bypass;
    logic [31:0] o_bypass_data;

    int checks = 0;
    int errors = 0;

    rv_muldiv_ctrl #(.EXTENSION_M(1'b1), .MUL_ITER(31), .DIV_ITER(33)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_flush       (i_flush),
        .i_start       (i_start),
        .i_funct3      (i_funct3),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .o_ready       (o_ready),
        .o_on_wait     (o_on_wait),
        .o_on_end      (o_on_end),
        .o_is_div      (o_is_div),
        .o_op_cnt      (o_op_cnt),
        .o_op1_signed  (o_op1_signed),
        .o_op2_signed  (o_op2_signed),
        .o_dr_signed   (o_dr_signed),
        .o_div_signed  (o_div_signed),
        .o_rem_signed  (o_rem_signed),
        .o_done        (o_done),
        .o_bypass      (o_bypass),
        .o_bypass_data (o_bypass_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        i_start  = 1'b1;
        i_funct3 = f3;
        i_op1    = a;
        i_op2    = b;
        step();
        i_start  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_wait"}, 32'(o_on_wait), 32'd0);
        chk({tag, "_end"}, 32'(o_on_end), 32'd0);
        chk({tag, "_isdiv"}, 32'(o_is_div), 32'd0);
        chk({tag, "_cnt"}, 32'(o_op_cnt), 32'd0);
        chk({tag, "_signs"}, 32'({o_op1_signed, o_op2_signed, o_dr_signed, o_div_signed, o_rem_signed}), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_bypass"}, 32'(o_bypass), 32'd0);
        chk({tag, "_bdata"}, o_bypass_data, 32'd0);
    endtask

    // Called in cycle 1 after accept; leaves the bench in the first ready cycle.
    task automatic run_check(input string tag, input int limit, input logic exp_div);
        for (int k = 1; k <= limit; k++) begin
            chk($sformatf("%s_wait%0d", tag, k), 32'(o_on_wait), 32'd1);
            chk($sformatf("%s_cnt%0d", tag, k), 32'(o_op_cnt), 32'(k - 1));
            chk($sformatf("%s_nodone%0d", tag, k), 32'(o_done | o_ready), 32'd0);
            step();
        end
        chk({tag, "_end"}, 32'(o_on_end), 32'd1);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_bypass"}, 32'(o_bypass), 32'd0);
        chk({tag, "_endcnt"}, 32'(o_op_cnt), 32'(limit));
        chk({tag, "_isdiv"}, 32'(o_is_div), 32'(exp_div));
        step();
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_donedrop"}, 32'(o_done), 32'd0);
        chk({tag, "_cntclr"}, 32'(o_op_cnt), 32'd0);
    endtask

    // Called in cycle 1 after accept of a special division.
    task automatic spec_check(input string tag, input logic [31:0] exp_data);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_bypass"}, 32'(o_bypass), 32'd1);
        chk({tag, "_wait"}, 32'(o_on_wait), 32'd0);
        chk({tag, "_data"}, o_bypass_data, exp_data);
        step();
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_donedrop"}, 32'(o_done | o_bypass), 32'd0);
        chk({tag, "_hold"}, o_bypass_data, exp_data);
    endtask

    initial begin
        @(negedge i_clk);
        step();
        check_reset_state("rst");
        i_reset_n = 1'b1;
        step();
        check_reset_state("idle");

        // MULHU: unsigned x unsigned
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu_op1s", 32'(o_op1_signed), 32'd0);
        chk("mulhu_op2s", 32'(o_op2_signed), 32'd0);
        run_check("mulhu", 31, 1'b0);

        // DIV back-to-back in the first ready cycle
        issue(3'b100, 32'd100, 32'd7);
        chk("div_divs", 32'(o_div_signed), 32'd1);
        chk("div_signs", 32'({o_op1_signed, o_op2_signed, o_dr_signed, o_rem_signed}), 32'b1110);
        run_check("div", 33, 1'b1);

        issue(3'b101, 32'd1234, 32'd0);
        spec_check("divu0", 32'hFFFF_FFFF);
        issue(3'b110, 32'd5, 32'd0);
        chk("rem0_rems", 32'(o_rem_signed), 32'd1);
        spec_check("rem0", 32'd5);
        issue(3'b111, 32'hDEAD_BEEF, 32'd0);
        spec_check("remu0", 32'hDEAD_BEEF);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        spec_check("divovf", 32'h8000_0000);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        spec_check("removf", 32'h0000_0000);

        // Unsigned INT_MIN / all-ones is an ordinary division; abort it with flush.
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divu_big_wait", 32'(o_on_wait), 32'd1);
        chk("divu_big_bypass", 32'(o_bypass), 32'd0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("divu_big_flush", 32'(o_ready), 32'd1);

        // Flush at RUN cycle 10
        issue(3'b000, 32'd3, 32'd4);
        for (int k = 1; k < 10; k++) step();
        chk("flush_cnt9", 32'(o_op_cnt), 32'd9);
        chk("flush_wait", 32'(o_on_wait), 32'd1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("flush_ready", 32'(o_ready), 32'd1);
        chk("flush_nodone", 32'(o_done | o_on_wait | o_on_end), 32'd0);
        chk("flush_cnt", 32'(o_op_cnt), 32'd0);
        issue(3'b000, 32'd3, 32'd4);
        run_check("mul_after_flush", 31, 1'b0);

        // Flush beats start in IDLE
        i_start = 1'b1;
        i_flush = 1'b1;
        step();
        i_start = 1'b0;
        i_flush = 1'b0;
        chk("flushprio_ready", 32'(o_ready), 32'd1);
        chk("flushprio_wait", 32'(o_on_wait | o_done), 32'd0);

        // Start while busy is ignored (DIVU then MUL pulses)
        issue(3'b101, 32'd100, 32'd7);
        for (int k = 1; k <= 33; k++) begin
            chk($sformatf("busy_cnt%0d", k), 32'(o_op_cnt), 32'(k - 1));
            chk($sformatf("busy_ctl%0d", k), 32'({o_is_div, o_dr_signed, o_div_signed}), 32'b100);
            i_start  = (k >= 5 && k <= 7);
            i_funct3 = 3'b000;
            step();
        end
        i_start = 1'b0;
        chk("busy_done", 32'(o_done), 32'd1);
        chk("busy_endcnt", 32'(o_op_cnt), 32'd33);
        step();
        chk("busy_ready", 32'(o_ready), 32'd1);

        // Reset mid-divide
        issue(3'b100, 32'd100, 32'd7);
        for (int k = 1; k < 15; k++) step();
        chk("rstmid_cnt", 32'(o_op_cnt), 32'd14);
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        check_reset_state("rstmid");

        // Reset during SPEC clears the held bypass data
        issue(3'b111, 32'hCAFE_F00D, 32'd0);
        chk("rstspec_data", o_bypass_data, 32'hCAFE_F00D);
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        check_reset_state("rstspec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
